// File: rtl/bsram_pkg.sv
// Shared types and helpers for the byte-enable BSRAM with clear engine.
`ifndef BSRAM_PKG_SV
`define BSRAM_PKG_SV

`define BSRAM_LATENCY_LEGAL(lat) (((lat) == 1) || ((lat) == 2))

package bsram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

endpackage

`endif

// File: rtl/bsram_byte_lane.sv
// One 8-bit wide lane of the BSRAM: storage, write port and read port with optional write-to-read bypass.
module bsram_byte_lane
  import bsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  logic [7:0] mem [0:2**ADDR_WIDTH-1];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A same-address write in the read cycle wins only when bypass is enabled.
  always_comb begin
    rd_data = mem[rd_addr];
    if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/bsram_byte_en_clear_pipe.sv
// Byte-writable synchronous RAM with 1- or 2-cycle read latency, write bypass and a whole-array clear engine.
module bsram_byte_en_clear_pipe
  import bsram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    readEnable,
  input  logic [ADDR_WIDTH-1:0]   readAddress,
  output logic [DATA_WIDTH-1:0]   readData,
  output logic                    readValid,
  input  logic                    writeEnable,
  input  logic [DATA_WIDTH/8-1:0] writeByteEnable,
  input  logic [ADDR_WIDTH-1:0]   writeAddress,
  input  logic [DATA_WIDTH-1:0]   writeData,
  input  logic                    clearStart,
  output logic                    ready,
  input  logic                    scan
);

  localparam int BYTES = bytes_of(DATA_WIDTH);
  // Illegal latency values fall back to the single-stage pipeline.
  localparam int DEPTH = `BSRAM_LATENCY_LEGAL(READ_LATENCY) ? READ_LATENCY : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [BYTES-1:0]        lane_we;
  logic [ADDR_WIDTH-1:0]   lane_waddr;
  logic [DATA_WIDTH-1:0]   lane_wdata;
  logic [DATA_WIDTH-1:0]   lane_rdata;
  logic                    rd_accept;
  logic [DATA_WIDTH-1:0]   rd_data_p1_q, rd_data_p1_d;
  logic                    vld_p1_q, vld_p1_d;
  logic                    unused_scan;

  // scan has no functional effect in this model.
  assign unused_scan = scan;

  assign ready     = (state_q == ST_IDLE);
  assign rd_accept = ready && readEnable;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clearStart) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear engine takes over every lane write port while it runs.
  always_comb begin
    lane_we    = '0;
    lane_waddr = writeAddress;
    lane_wdata = writeData;
    if (state_q == ST_CLEAR) begin
      lane_we    = '1;
      lane_waddr = clr_cnt_q;
      lane_wdata = '0;
    end else if (writeEnable) begin
      lane_we = writeByteEnable;
    end
  end

  bsram_byte_lane #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) lane [BYTES-1:0] (
    .clock   (clock),
    .wr_en   (lane_we),
    .wr_addr (lane_waddr),
    .wr_data (lane_wdata),
    .rd_addr (readAddress),
    .rd_data (lane_rdata)
  );

  // Stage p1: array sample
  always_comb begin
    vld_p1_d     = rd_accept;
    rd_data_p1_d = rd_accept ? lane_rdata : rd_data_p1_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      clr_cnt_q    <= '0;
      rd_data_p1_q <= '0;
      vld_p1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      rd_data_p1_q <= rd_data_p1_d;
      vld_p1_q     <= vld_p1_d;
    end
  end

  // Stage p2: optional output register
  generate
    if (DEPTH == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rd_data_p2_q, rd_data_p2_d;
      logic                  vld_p2_q, vld_p2_d;

      always_comb begin
        vld_p2_d     = vld_p1_q;
        rd_data_p2_d = vld_p1_q ? rd_data_p1_q : rd_data_p2_q;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rd_data_p2_q <= '0;
          vld_p2_q     <= 1'b0;
        end else begin
          rd_data_p2_q <= rd_data_p2_d;
          vld_p2_q     <= vld_p2_d;
        end
      end

      assign readData  = rd_data_p2_q;
      assign readValid = vld_p2_q;
    end else begin : g_lat1
      assign readData  = rd_data_p1_q;
      assign readValid = vld_p1_q;
    end
  endgenerate

endmodule

// File: tb/tb_bsram_byte_en_clear_pipe.sv
// Directed bench: four configurations (default, no bypass, latency 2, no clear on reset) share one stimulus.
module tb_bsram_byte_en_clear_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we, cs, scan;
  logic [7:0]  raddr, waddr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic [31:0] rdata [4];
  logic        rvld  [4];
  logic        rdy   [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsram_byte_en_clear_pipe #(.READ_LATENCY(1), .BYPASS(1), .CLEAR_ON_RESET(1)) dut (
    .clock(clk), .reset(rst), .readEnable(re), .readAddress(raddr), .readData(rdata[0]),
    .readValid(rvld[0]), .writeEnable(we), .writeByteEnable(be), .writeAddress(waddr),
    .writeData(wdata), .clearStart(cs), .ready(rdy[0]), .scan(scan));

  bsram_byte_en_clear_pipe #(.READ_LATENCY(1), .BYPASS(0), .CLEAR_ON_RESET(1)) dut_nb (
    .clock(clk), .reset(rst), .readEnable(re), .readAddress(raddr), .readData(rdata[1]),
    .readValid(rvld[1]), .writeEnable(we), .writeByteEnable(be), .writeAddress(waddr),
    .writeData(wdata), .clearStart(cs), .ready(rdy[1]), .scan(scan));

  bsram_byte_en_clear_pipe #(.READ_LATENCY(2), .BYPASS(1), .CLEAR_ON_RESET(1)) dut_l2 (
    .clock(clk), .reset(rst), .readEnable(re), .readAddress(raddr), .readData(rdata[2]),
    .readValid(rvld[2]), .writeEnable(we), .writeByteEnable(be), .writeAddress(waddr),
    .writeData(wdata), .clearStart(cs), .ready(rdy[2]), .scan(scan));

  bsram_byte_en_clear_pipe #(.READ_LATENCY(1), .BYPASS(1), .CLEAR_ON_RESET(0)) dut_nc (
    .clock(clk), .reset(rst), .readEnable(re), .readAddress(raddr), .readData(rdata[3]),
    .readValid(rvld[3]), .writeEnable(we), .writeByteEnable(be), .writeAddress(waddr),
    .writeData(wdata), .clearStart(cs), .ready(rdy[3]), .scan(scan));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    re = 1'b0; we = 1'b0; cs = 1'b0; be = 4'h0;
    raddr = 8'h00; waddr = 8'h00; wdata = 32'h0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; waddr = a; wdata = d; be = b;
    @(negedge clk);
    we = 1'b0; be = 4'h0;
  endtask

  // Counts negedge samples with ready low per instance, bounded to 1000 cycles.
  task automatic count_not_ready(output int lo [4]);
    lo = '{default: 0};
    for (int c = 0; c < 1000; c++) begin
      if (rdy[0] === 1'b1 && rdy[1] === 1'b1 && rdy[2] === 1'b1 && rdy[3] === 1'b1) break;
      for (int d = 0; d < 4; d++) if (rdy[d] !== 1'b1) lo[d]++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int lo [4];
    rst = 1'b1; scan = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rvld[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: readData=%h readValid=%b, want 00000000/0", d, rdata[d], rvld[d]);
      end
    end
    checks++;
    if (rdy[0] !== 1'b0) begin errors++; $display("FAIL reset_ready_clear: ready=%b want 0", rdy[0]); end
    checks++;
    if (rdy[3] !== 1'b1) begin errors++; $display("FAIL reset_ready_noclear: ready=%b want 1", rdy[3]); end
    rst = 1'b0;
    count_not_ready(lo);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (lo[d] !== ((d == 3) ? 0 : 256)) begin
        errors++;
        $display("FAIL reset_clear_len dut%0d: not-ready cycles=%0d want %0d", d, lo[d], (d == 3) ? 0 : 256);
      end
    end
    for (int a = 0; a < 256; a++) begin
      re = 1'b1; raddr = 8'(a);
      @(negedge clk);
      checks++;
      if (rvld[0] !== 1'b1 || rdata[0] !== 32'h0) begin
        errors++;
        $display("FAIL cleared_word[%0d]: readData=%h readValid=%b, want 00000000/1", a, rdata[0], rvld[0]);
      end
    end
    re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_byte_write();
    do_write(8'd2, 32'hAAAA8888, 4'b1111);
    do_write(8'd2, 32'h00000064, 4'b0011);
    do_write(8'd2, 32'hFFFFFFFF, 4'b0000);
    re = 1'b1; raddr = 8'd2;
    @(negedge clk);
    re = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (d == 2) continue;
      checks++;
      if (rvld[d] !== 1'b1 || rdata[d] !== 32'hAAAA0064) begin
        errors++;
        $display("FAIL byte_write dut%0d: readData=%h readValid=%b, want AAAA0064/1", d, rdata[d], rvld[d]);
      end
    end
    checks++;
    if (rvld[2] !== 1'b0) begin errors++; $display("FAIL lat2_early_valid: readValid=%b want 0", rvld[2]); end
    @(negedge clk);
    checks++;
    if (rvld[2] !== 1'b1 || rdata[2] !== 32'hAAAA0064) begin
      errors++;
      $display("FAIL byte_write_lat2: readData=%h readValid=%b, want AAAA0064/1", rdata[2], rvld[2]);
    end
    checks++;
    if (rvld[0] !== 1'b0 || rdata[0] !== 32'hAAAA0064) begin
      errors++;
      $display("FAIL read_hold: readData=%h readValid=%b, want AAAA0064/0", rdata[0], rvld[0]);
    end
  endtask

  task automatic test_bypass();
    do_write(8'd5, 32'hFFFFFFFF, 4'b1111);
    we = 1'b1; waddr = 8'd5; wdata = 32'h12345678; be = 4'b1000;
    re = 1'b1; raddr = 8'd5;
    @(negedge clk);
    we = 1'b0; be = 4'h0; re = 1'b0;
    checks++;
    if (rdata[0] !== 32'h12FFFFFF) begin errors++; $display("FAIL bypass_on: readData=%h want 12FFFFFF", rdata[0]); end
    checks++;
    if (rdata[1] !== 32'hFFFFFFFF) begin errors++; $display("FAIL bypass_off: readData=%h want FFFFFFFF", rdata[1]); end
    @(negedge clk);
    checks++;
    if (rdata[2] !== 32'h12FFFFFF || rvld[2] !== 1'b1) begin
      errors++;
      $display("FAIL bypass_lat2: readData=%h readValid=%b want 12FFFFFF/1", rdata[2], rvld[2]);
    end
    we = 1'b1; waddr = 8'd6; wdata = 32'hCAFEF00D; be = 4'b1111;
    re = 1'b1; raddr = 8'd5;
    @(negedge clk);
    we = 1'b0; be = 4'h0;
    checks++;
    if (rdata[1] !== 32'h12FFFFFF || rvld[1] !== 1'b1) begin
      errors++;
      $display("FAIL indep_rw_read: readData=%h readValid=%b want 12FFFFFF/1", rdata[1], rvld[1]);
    end
    raddr = 8'd6;
    @(negedge clk);
    re = 1'b0;
    checks++;
    if (rdata[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL indep_rw_write: readData=%h want CAFEF00D", rdata[0]); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d0 [5];
    logic        exp_v0 [5];
    logic [31:0] exp_d2 [5];
    logic        exp_v2 [5];
    exp_d0 = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};
    exp_v0 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_d2 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd3};
    exp_v2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_write(8'd0, 32'd1, 4'b1111);
    do_write(8'd1, 32'd2, 4'b1111);
    do_write(8'd2, 32'd3, 4'b1111);
    for (int k = 0; k < 5; k++) begin
      re = (k < 3); raddr = 8'(k);
      @(negedge clk);
      checks++;
      if (rvld[0] !== exp_v0[k] || rdata[0] !== exp_d0[k]) begin
        errors++;
        $display("FAIL b2b_lat1[%0d]: readData=%h readValid=%b want %h/%b", k, rdata[0], rvld[0], exp_d0[k], exp_v0[k]);
      end
      checks++;
      if (rvld[2] !== exp_v2[k] || (k > 0 && rdata[2] !== exp_d2[k])) begin
        errors++;
        $display("FAIL b2b_lat2[%0d]: readData=%h readValid=%b want %h/%b", k, rdata[2], rvld[2], exp_d2[k], exp_v2[k]);
      end
    end
    re = 1'b0;
  endtask

  task automatic test_clear();
    int lo [4];
    lo = '{default: 0};
    cs = 1'b1; re = 1'b1; raddr = 8'd2;
    @(negedge clk);
    cs = 1'b0; re = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (rdy[0] === 1'b1 && rdy[1] === 1'b1 && rdy[2] === 1'b1 && rdy[3] === 1'b1) break;
      for (int d = 0; d < 4; d++) if (rdy[d] !== 1'b1) lo[d]++;
      if (c == 1) begin
        checks++;
        if (rvld[2] !== 1'b1 || rdata[2] !== 32'd3) begin
          errors++;
          $display("FAIL inflight_lat2: readData=%h readValid=%b want 00000003/1", rdata[2], rvld[2]);
        end
      end
      if (c == 10) begin
        we = 1'b1; waddr = 8'd7; wdata = 32'hDEADBEEF; be = 4'b1111;
        re = 1'b1; raddr = 8'd7;
      end
      if (c == 11) begin
        we = 1'b0; be = 4'h0; re = 1'b0;
        checks++;
        if (rvld[0] !== 1'b0 || rvld[1] !== 1'b0 || rvld[3] !== 1'b0) begin
          errors++;
          $display("FAIL clear_read_dropped: readValid=%b%b%b want 000", rvld[0], rvld[1], rvld[3]);
        end
      end
      if (c == 12) begin
        checks++;
        if (rvld[2] !== 1'b0) begin errors++; $display("FAIL clear_read_dropped_lat2: readValid=%b want 0", rvld[2]); end
      end
      @(negedge clk);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (lo[d] !== 256) begin
        errors++;
        $display("FAIL clear_len dut%0d: not-ready cycles=%0d want 256", d, lo[d]);
      end
    end
    re = 1'b1; raddr = 8'd7;
    @(negedge clk);
    re = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (d == 2) continue;
      checks++;
      if (rvld[d] !== 1'b1 || rdata[d] !== 32'h0) begin
        errors++;
        $display("FAIL clear_write_dropped dut%0d: readData=%h readValid=%b want 00000000/1", d, rdata[d], rvld[d]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_clear();
    int lo [4];
    scan = 1'b1;
    do_write(8'd50, 32'h00000066, 4'b1111);
    do_write(8'd200, 32'h00000055, 4'b1111);
    cs = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rvld[0] !== 1'b0 || rdata[0] !== 32'h0 || rdata[2] !== 32'h0) begin
      errors++;
      $display("FAIL midclear_reset_regs: readData=%h/%h readValid=%b want 0", rdata[0], rdata[2], rvld[0]);
    end
    checks++;
    if (rdy[0] !== 1'b0 || rdy[3] !== 1'b1) begin
      errors++;
      $display("FAIL midclear_reset_ready: ready=%b/%b want 0/1", rdy[0], rdy[3]);
    end
    rst = 1'b0;
    count_not_ready(lo);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (lo[d] !== ((d == 3) ? 0 : 256)) begin
        errors++;
        $display("FAIL midclear_restart dut%0d: not-ready cycles=%0d want %0d", d, lo[d], (d == 3) ? 0 : 256);
      end
    end
    re = 1'b1; raddr = 8'd200;
    @(negedge clk);
    checks++;
    if (rdata[0] !== 32'h0) begin errors++; $display("FAIL midclear_full_clear: readData=%h want 00000000", rdata[0]); end
    checks++;
    if (rdata[3] !== 32'h00000055) begin errors++; $display("FAIL abandoned_kept: readData=%h want 00000055", rdata[3]); end
    raddr = 8'd50;
    @(negedge clk);
    re = 1'b0;
    checks++;
    if (rdata[3] !== 32'h0) begin errors++; $display("FAIL abandoned_partial: readData=%h want 00000000", rdata[3]); end
    scan = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_bypass();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
